// File: rtl/wb_port_arbiter.sv
`default_nettype none
// wb_port_arbiter: shares the register-file write port between pipeline writeback and a buffered MCU result FIFO.
// Optional macro WBARB_PERF_EN adds steal/squash event counters.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wb_we_i,
  input  logic [4:0]                 wb_rd_i,
  input  logic [31:0]                wb_data_i,
  input  logic                       mcu_valid_i,
  input  logic [4:0]                 mcu_rd_i,
  input  logic [31:0]                mcu_data_i,
  output logic                       mcu_ready_o,
  output logic                       stall_o,
  output logic                       rf_we_o,
  output logic [4:0]                 rf_addr_o,
  output logic [31:0]                rf_data_o,
  output logic [$clog2(DEPTH+1)-1:0] pending_o
`ifdef WBARB_PERF_EN
  ,
  output logic [31:0]                steal_cnt_o,
  output logic [31:0]                squash_cnt_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int AGE_W = $clog2(STARVE_LIMIT+1);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_STEAL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_data_q, rf_data_d;

  logic [4:0]       ent_rd_q   [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0] ent_sq_q;

  logic empty, head_sq, head_live, pipe_wr, pop, push, store;

  always_comb begin
    empty     = (count_q == '0);
    head_sq   = ent_sq_q[rd_ptr_q];
    head_live = !empty && !head_sq;
    pipe_wr   = (state_q == S_RUN) && wb_we_i && (wb_rd_i != 5'd0);
    // A stolen slot always pops; otherwise the head only gets slots the pipeline leaves free.
    pop       = !empty && ((state_q == S_STEAL) || !pipe_wr);
    push      = mcu_valid_i && mcu_ready_o;
    store     = push && (mcu_rd_i != 5'd0);
  end

  always_comb begin
    wr_ptr_d = store ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(store) - CNT_W'(pop);

    age_d = age_q;
    if (empty || pop || head_sq) begin
      age_d = '0;
    end else if (age_q != '1) begin
      age_d = age_q + AGE_W'(1);
    end

    rf_we_d   = pop ? !head_sq : pipe_wr;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (pipe_wr) begin
      rf_addr_d = wb_rd_i;
      rf_data_d = wb_data_i;
    end else if (pop && !head_sq) begin
      rf_addr_d = ent_rd_q[rd_ptr_q];
      rf_data_d = ent_data_q[rd_ptr_q];
    end
  end

  // Starvation FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Starvation FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (head_live && !pop && (age_q == AGE_W'(STARVE_LIMIT-1))) begin
          state_d = S_STEAL;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Starvation FSM: outputs
  always_comb begin
    stall_o     = (state_q == S_STEAL);
    mcu_ready_o = (count_q != CNT_W'(DEPTH));
    pending_o   = count_q;
    rf_we_o     = rf_we_q;
    rf_addr_o   = rf_addr_q;
    rf_data_o   = rf_data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      age_q     <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      age_q     <= age_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // MCU results are older than the WB instruction, so a matching entry pushed this cycle is squashed too.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent_sq_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_wr && (ent_rd_q[i] == wb_rd_i)) begin
          ent_sq_q[i] <= 1'b1;
        end
      end
      if (store) begin
        ent_sq_q[wr_ptr_q] <= pipe_wr && (mcu_rd_i == wb_rd_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      ent_rd_q[wr_ptr_q]   <= mcu_rd_i;
      ent_data_q[wr_ptr_q] <= mcu_data_i;
    end
  end

`ifdef WBARB_PERF_EN
  logic [31:0] steal_cnt_q, squash_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      steal_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (state_q == S_STEAL) begin
        steal_cnt_q <= steal_cnt_q + 32'd1;
      end
      if (pop && head_sq) begin
        squash_cnt_q <= squash_cnt_q + 32'd1;
      end
    end
  end

  assign steal_cnt_o  = steal_cnt_q;
  assign squash_cnt_o = squash_cnt_q;
`endif

endmodule
`default_nettype wire
